// File: rtl/arb_mux_pkg.sv
// Shared types and sizing helpers for the arb_mux packet arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   lock_state_t : packet-lock FSM state (IDLE, LOCKED)
//   ptr_w()      : width of the round-robin pointer, clog2(PORT_NUM) with a floor of 1
package arb_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // A single-port arbiter still needs a 1-bit pointer so vectors stay legal.
    function automatic int ptr_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating-base priority pick: first set bit of i_valid at or above i_base, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_valid [N-1:0] : request vector
//   i_base  [W-1:0] : index searched first (must be < N)
//   o_grant [N-1:0] : one-hot winner, all zero when i_valid is zero
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_base,
    output logic [N-1:0] o_grant
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_pick;

    // Rotate requests right by base so the search always starts at bit 0.
    assign w_rot  = N'({i_valid, i_valid} >> i_base);
    // Lowest set bit of the rotated vector.
    assign w_pick = w_rot & (-w_rot);
    // Rotate the one-hot back left by base; the upper half holds the wrapped result.
    assign o_grant = N'(({w_pick, w_pick} << i_base) >> N);

endmodule

// File: rtl/arb_mux.sv
// N:1 valid/ready arbiter-mux with a registered output beat; round-robin or fixed priority.
// Latency: 1 cycle from input transfer to valid_o.
// Backpressure: ready_o only to the winner and only when the output register is empty or draining.
//
// Ports:
//   clk_i, rst_n_i              : clock, synchronous active-low reset
//   data_i/valid_i/last_i       : PORT_NUM packed input channels (channel k at data_i[k*DW +: DW])
//   ready_o                     : per-channel accept, at most one bit set
//   data_o/valid_o/last_o       : registered output beat
//   grant_o                     : one-hot source of the beat on data_o, zero when valid_o=0
//   ready_i                     : downstream accept
// Build option: define ARB_MUX_PKT_LOCK_EN to hold the grant on one channel until its last beat.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PORT_NUM   = 4,
    parameter int RR_EN      = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [DATA_WIDTH*PORT_NUM-1:0] data_i,
    input  logic [PORT_NUM-1:0]            valid_i,
    input  logic [PORT_NUM-1:0]            last_i,
    output logic [PORT_NUM-1:0]            ready_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           valid_o,
    output logic                           last_o,
    input  logic                           ready_i,
    output logic [PORT_NUM-1:0]            grant_o
);

    localparam int PW = ptr_w(PORT_NUM);

    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [PORT_NUM-1:0]   r_grant;
    logic [PW-1:0]         r_ptr;

    logic                  w_load;
    logic                  w_in_xfer;
    logic                  w_release;
    logic                  w_win_last;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [PW-1:0]         w_win_idx;
    logic [PW-1:0]         w_base;
    logic [PW-1:0]         w_ptr_nxt;
    logic [PORT_NUM-1:0]   w_req;
    logic [PORT_NUM-1:0]   w_win_oh;
    logic [PORT_NUM-1:0]   w_ready;

`ifdef ARB_MUX_PKT_LOCK_EN
    lock_state_t         r_state;
    logic [PORT_NUM-1:0] r_lock_oh;

    // While locked only the owning channel is visible to the picker, so other
    // channels wait even when the owner has a bubble in its packet.
    assign w_req     = (r_state == LOCKED) ? (valid_i & r_lock_oh) : valid_i;
    assign w_release = w_in_xfer && w_win_last;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_lock_oh <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_xfer && !w_win_last) begin
                        r_state   <= LOCKED;
                        r_lock_oh <= w_win_oh;
                    end
                end
                LOCKED: begin
                    if (w_release) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
`else
    // Every beat is arbitrated independently; last_i is only forwarded.
    assign w_req     = valid_i;
    assign w_release = w_in_xfer;
`endif

    assign w_base = (RR_EN != 0) ? r_ptr : '0;

    rr_pick #(
        .N (PORT_NUM),
        .W (PW)
    ) u_pick (
        .i_valid (w_req),
        .i_base  (w_base),
        .o_grant (w_win_oh)
    );

    assign w_load    = !r_valid || ready_i;
    assign w_ready   = (rst_n_i && w_load) ? w_win_oh : '0;
    assign w_in_xfer = |(valid_i & w_ready);

    // One-hot select of the winner's beat and its index.
    always_comb begin
        w_win_data = '0;
        w_win_last = 1'b0;
        w_win_idx  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (w_win_oh[i]) begin
                w_win_data = data_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_win_last = last_i[i];
                w_win_idx  = PW'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_win_idx == PW'(PORT_NUM - 1)) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_valid <= 1'b1;
                r_last  <= w_win_last;
                r_data  <= w_win_data;
                r_grant <= w_win_oh;
            end else if (w_load) begin
                // Drained (or already empty) with nothing new: data/last keep their value.
                r_valid <= 1'b0;
                r_grant <= '0;
            end
            if (w_release) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign ready_o = w_ready;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign grant_o = r_grant;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: fixed-priority, round-robin and single-port instances share stimulus.
// Latency: n/a.
// Backpressure: ready_i driven directly by the scenarios.
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_i;
    logic [3:0]  valid_i;
    logic [3:0]  last_i;
    logic        ready_i;

    logic [3:0] fp_ready, fp_grant, rr_ready, rr_grant;
    logic [7:0] fp_data, rr_data, one_data;
    logic       fp_valid, fp_last, rr_valid, rr_last, one_valid, one_last;
    logic [0:0] one_ready, one_grant;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_g [6];
    logic       exp_l [6];
    logic [7:0] exp_d [6];

    always #5 clk = ~clk;

    arb_mux #(.DATA_WIDTH(8), .PORT_NUM(4), .RR_EN(0)) u_fp (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
        .ready_o(fp_ready), .data_o(fp_data), .valid_o(fp_valid), .last_o(fp_last),
        .ready_i(ready_i), .grant_o(fp_grant)
    );

    arb_mux #(.DATA_WIDTH(8), .PORT_NUM(4), .RR_EN(1)) u_rr (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
        .ready_o(rr_ready), .data_o(rr_data), .valid_o(rr_valid), .last_o(rr_last),
        .ready_i(ready_i), .grant_o(rr_grant)
    );

    arb_mux #(.DATA_WIDTH(8), .PORT_NUM(1), .RR_EN(1)) u_one (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i[7:0]), .valid_i(valid_i[0:0]),
        .last_i(last_i[0:0]), .ready_o(one_ready), .data_o(one_data), .valid_o(one_valid),
        .last_o(one_last), .ready_i(ready_i), .grant_o(one_grant)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        valid_i = 4'b0000;
        step();
        rst_n   = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        data_i  = 32'h33221100;
        step();
        step();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rr_valid); end
        checks++; if (rr_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", rr_grant); end
        checks++; if (rr_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rr_data); end
        checks++; if (rr_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", rr_last); end
        checks++; if (rr_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_rr got=%b exp=0000", rr_ready); end
        checks++; if (fp_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_fp got=%b exp=0000", fp_ready); end
    endtask

    task automatic test_fixed_prio;
        do_reset();
        data_i  = 32'h33221100;
        valid_i = 4'b1010;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        #1;
        checks++; if (fp_ready !== 4'b0010) begin failures++; $display("FAIL fp_ready_first got=%b exp=0010", fp_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (fp_grant !== 4'b0010) begin failures++; $display("FAIL fp_grant cyc=%0d got=%b exp=0010", c, fp_grant); end
            checks++; if (fp_data !== 8'h11) begin failures++; $display("FAIL fp_data cyc=%0d got=%h exp=11", c, fp_data); end
            checks++; if (fp_ready[3] !== 1'b0) begin failures++; $display("FAIL fp_starve cyc=%0d got=%b exp=0", c, fp_ready[3]); end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] g_tab [5];
        logic [7:0] d_tab [5];
        g_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d_tab = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        do_reset();
        data_i  = 32'h33221100;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (rr_grant !== g_tab[c]) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, rr_grant, g_tab[c]); end
            checks++; if (rr_data !== d_tab[c]) begin failures++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, rr_data, d_tab[c]); end
            checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=1", c, rr_valid); end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        data_i  = 32'h000000A5;
        valid_i = 4'b0001;
        last_i  = 4'b0001;
        ready_i = 1'b1;
        step();
        checks++; if (rr_data !== 8'hA5) begin failures++; $display("FAIL bp_load_data got=%h exp=a5", rr_data); end
        checks++; if (one_data !== 8'hA5) begin failures++; $display("FAIL bp_one_data got=%h exp=a5", one_data); end
        ready_i = 1'b0;
        data_i  = 32'h0000005A;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rr_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, rr_ready); end
            checks++; if (one_ready !== 1'b0) begin failures++; $display("FAIL bp_one_ready cyc=%0d got=%b exp=0", c, one_ready); end
            step();
            checks++; if (rr_data !== 8'hA5) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=a5", c, rr_data); end
            checks++; if (rr_grant !== 4'b0001) begin failures++; $display("FAIL bp_hold_grant cyc=%0d got=%b exp=0001", c, rr_grant); end
            checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, rr_valid); end
        end
        ready_i = 1'b1;
        #1;
        checks++; if (rr_ready !== 4'b0001) begin failures++; $display("FAIL bp_resume_ready got=%b exp=0001", rr_ready); end
        checks++; if (one_ready !== 1'b1) begin failures++; $display("FAIL bp_one_resume got=%b exp=1", one_ready); end
        step();
        checks++; if (rr_data !== 8'h5A) begin failures++; $display("FAIL bp_next_data got=%h exp=5a", rr_data); end
        valid_i = 4'b0000;
        step();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", rr_valid); end
        checks++; if (rr_grant !== 4'b0000) begin failures++; $display("FAIL bp_drain_grant got=%b exp=0000", rr_grant); end
        checks++; if (rr_data !== 8'h5A) begin failures++; $display("FAIL bp_drain_data got=%h exp=5a", rr_data); end
    endtask

    task automatic test_packet;
        int  b1;
        int  ncyc;
        logic acc;
`ifdef ARB_MUX_PKT_LOCK_EN
        ncyc = 4;
        exp_g[0] = 4'b0010; exp_l[0] = 1'b0; exp_d[0] = 8'hB0;
        exp_g[1] = 4'b0010; exp_l[1] = 1'b0; exp_d[1] = 8'hB1;
        exp_g[2] = 4'b0010; exp_l[2] = 1'b1; exp_d[2] = 8'hB2;
        exp_g[3] = 4'b0001; exp_l[3] = 1'b1; exp_d[3] = 8'hC0;
`else
        ncyc = 6;
        exp_g[0] = 4'b0010; exp_l[0] = 1'b0; exp_d[0] = 8'hB0;
        exp_g[1] = 4'b0001; exp_l[1] = 1'b1; exp_d[1] = 8'hC0;
        exp_g[2] = 4'b0010; exp_l[2] = 1'b0; exp_d[2] = 8'hB1;
        exp_g[3] = 4'b0001; exp_l[3] = 1'b1; exp_d[3] = 8'hC0;
        exp_g[4] = 4'b0010; exp_l[4] = 1'b1; exp_d[4] = 8'hB2;
        exp_g[5] = 4'b0001; exp_l[5] = 1'b1; exp_d[5] = 8'hC0;
`endif
        do_reset();
        // One single-beat transfer from channel 0 moves the pointer to channel 1.
        data_i  = 32'h0000B0C0;
        valid_i = 4'b0001;
        last_i  = 4'b0001;
        ready_i = 1'b1;
        step();
        checks++; if (rr_grant !== 4'b0001) begin failures++; $display("FAIL pkt_pre_grant got=%b exp=0001", rr_grant); end
        b1 = 0;
        for (int c = 0; c < ncyc; c++) begin
            valid_i       = {2'b00, (b1 < 3), 1'b1};
            last_i        = {2'b00, (b1 == 2), 1'b1};
            data_i[15:8]  = 8'hB0 + 8'(b1);
            #1;
            acc = rr_ready[1];
            step();
            checks++; if (rr_grant !== exp_g[c]) begin failures++; $display("FAIL pkt_grant cyc=%0d got=%b exp=%b", c, rr_grant, exp_g[c]); end
            checks++; if (rr_last !== exp_l[c]) begin failures++; $display("FAIL pkt_last cyc=%0d got=%b exp=%b", c, rr_last, exp_l[c]); end
            checks++; if (rr_data !== exp_d[c]) begin failures++; $display("FAIL pkt_data cyc=%0d got=%h exp=%h", c, rr_data, exp_d[c]); end
            if (acc) b1++;
        end
        valid_i = 4'b0000;
        step();
    endtask

    task automatic test_lock_reset;
        logic [3:0] exp_rdy;
        logic [3:0] exp_gnt;
        logic       exp_vld;
`ifdef ARB_MUX_PKT_LOCK_EN
        exp_rdy = 4'b0000; exp_gnt = 4'b0000; exp_vld = 1'b0;
`else
        exp_rdy = 4'b0001; exp_gnt = 4'b0001; exp_vld = 1'b1;
`endif
        do_reset();
        data_i  = 32'h0000B0C0;
        ready_i = 1'b1;
        valid_i = 4'b0001;
        last_i  = 4'b0001;
        step();
        checks++; if (rr_grant !== 4'b0001) begin failures++; $display("FAIL lk_first got=%b exp=0001", rr_grant); end
        valid_i = 4'b0010;
        last_i  = 4'b0000;
        step();
        checks++; if (rr_grant !== 4'b0010) begin failures++; $display("FAIL lk_open got=%b exp=0010", rr_grant); end
        // Owner goes idle mid-packet; another channel asks.
        valid_i = 4'b0001;
        last_i  = 4'b0001;
        #1;
        checks++; if (rr_ready !== exp_rdy) begin failures++; $display("FAIL lk_wait_ready got=%b exp=%b", rr_ready, exp_rdy); end
        step();
        checks++; if (rr_valid !== exp_vld) begin failures++; $display("FAIL lk_wait_valid got=%b exp=%b", rr_valid, exp_vld); end
        checks++; if (rr_grant !== exp_gnt) begin failures++; $display("FAIL lk_wait_grant got=%b exp=%b", rr_grant, exp_gnt); end
        rst_n   = 1'b0;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        #1;
        checks++; if (rr_ready !== 4'b0000) begin failures++; $display("FAIL lk_rst_ready got=%b exp=0000", rr_ready); end
        step();
        checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL lk_rst_valid got=%b exp=0", rr_valid); end
        checks++; if (rr_grant !== 4'b0000) begin failures++; $display("FAIL lk_rst_grant got=%b exp=0000", rr_grant); end
        rst_n = 1'b1;
        #1;
        checks++; if (rr_ready !== 4'b0001) begin failures++; $display("FAIL lk_post_ready got=%b exp=0001", rr_ready); end
        step();
        checks++; if (rr_grant !== 4'b0001) begin failures++; $display("FAIL lk_post_grant got=%b exp=0001", rr_grant); end
    endtask

    initial begin
        rst_n   = 1'b0;
        data_i  = '0;
        valid_i = '0;
        last_i  = '0;
        ready_i = 1'b0;
        test_reset();
        test_fixed_prio();
        test_round_robin();
        test_backpressure();
        test_packet();
        test_lock_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
